// File: rtl/display_7seg_scanner_if.sv
// Signal bundle between the display-source logic and the 7-segment scanner.
// master = source of the display word, slave = scanner driving the board pins.
interface display_7seg_scanner_if;
  logic [31:0] to_display;
  logic [7:0]  dp_mask;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;

  modport master (output to_display, dp_mask, input anodes, segments, dp);
  modport slave  (input to_display, dp_mask, output anodes, segments, dp);
endinterface

// File: rtl/display_7seg_scanner.sv
// Time-multiplexed 8-digit 7-segment scanner with a wrap-aligned shadow copy of the input word.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_7seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  display_7seg_scanner_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_MAX = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       dp_sh_q, dp_sh_d;
  logic             load_pend_q, load_pend_d;
  logic [7:0]       anodes_q, anodes_d;
  logic [6:0]       segments_q, segments_d;
  logic             dp_q, dp_d;

  logic             last_slot;
  logic             capture;
  logic [3:0]       nibble;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] msd;
`endif

  // NOTE: every next-state value gets a default on each path through this block, so no latches form.
  always_comb begin
    last_slot = (cnt_q == CNT_MAX);
    cnt_d     = last_slot ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (last_slot) idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;

    // Input is only sampled once per full scan so a digit never mixes old and new words.
    capture     = load_pend_q || (last_slot && (idx_q == IDX_MAX));
    shadow_d    = capture ? bus.to_display : shadow_q;
    dp_sh_d     = capture ? bus.dp_mask    : dp_sh_q;
    load_pend_d = 1'b0;

    nibble     = shadow_q[{idx_q, 2'b00} +: 4];
    anodes_d   = ~(8'b1 << idx_q);
    segments_d = glyph(nibble);
    dp_d       = ~dp_sh_q[idx_q];

`ifdef LEADING_ZERO_BLANK_EN
    msd = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (shadow_q[4*k +: 4] != 4'h0) msd = 3'(k);
    end
    if (idx_q > msd) begin
      anodes_d   = 8'hFF;
      segments_d = 7'h7F;
      dp_d       = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; the shadow is a register, not a memory, so it is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shadow_q    <= 32'h0;
      dp_sh_q     <= 8'h0;
      load_pend_q <= 1'b1;
      anodes_q    <= 8'hFF;
      segments_q  <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      dp_sh_q     <= dp_sh_d;
      load_pend_q <= load_pend_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.anodes   = anodes_q;
  assign bus.segments = segments_q;
  assign bus.dp       = dp_q;

endmodule
